// File: rtl/ram_access_controller.sv
// ram_access_controller: sequences single-word CPU reads/writes onto the asynchronous
// RAM with setup, strobe and hold phases so address/data never move under a strobe.
//
//   state  | meaning
//   IDLE   | waiting for req; mem_address/mem_datain keep their last values
//   SETUP  | address (and write data) presented, strobes low
//   STROBE | read or write strobe high for WAITSTATES+1 cycles
//   HOLD   | strobes low, address/data held
//   DONE   | ack pulse, err valid
module ram_access_controller #(
  parameter int ADLINES    = 8,
  parameter int DATALINES  = 16,
  parameter int RAMSIZE    = 256,
  parameter int WAITSTATES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [ADLINES-1:0]   i_addr,
  input  logic [DATALINES-1:0] i_wdata,
  output logic                 o_ack,
  output logic                 o_err,
  output logic [DATALINES-1:0] o_rdata,
  output logic                 o_busy,
  output logic [ADLINES-1:0]   o_mem_address,
  output logic [DATALINES-1:0] o_mem_datain,
  input  logic [DATALINES-1:0] i_mem_dataout,
  output logic                 o_mem_read,
  output logic                 o_mem_write
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

  localparam logic [ADLINES:0] LP_RAMSIZE = (ADLINES+1)'(RAMSIZE);
  localparam logic [3:0]       LP_WAIT    = 4'(WAITSTATES);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_we, w_we_nxt;
  logic                   r_ack, w_ack_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_rd, w_rd_nxt;
  logic                   r_wr, w_wr_nxt;
  logic [DATALINES-1:0]   r_rdata, w_rdata_nxt;
  logic [ADLINES-1:0]     r_maddr, w_maddr_nxt;
  logic [DATALINES-1:0]   r_mdin, w_mdin_nxt;
  logic                   w_out_of_range;

  assign w_out_of_range = ({1'b0, i_addr} >= LP_RAMSIZE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = 1'b1;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_rdata_nxt = r_rdata;
    w_maddr_nxt = r_maddr;
    w_mdin_nxt  = r_mdin;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_req) begin
          w_we_nxt   = i_we;
          w_busy_nxt = 1'b1;
          // Out-of-range requests never touch the RAM lines.
          if (w_out_of_range) begin
            w_state_nxt = S_DONE;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_SETUP;
            w_maddr_nxt = i_addr;
            if (i_we) w_mdin_nxt = i_wdata;
          end
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = LP_WAIT;
        w_rd_nxt    = ~r_we;
        w_wr_nxt    = r_we;
      end
      S_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
          if (!r_we) w_rdata_nxt = i_mem_dataout;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_rd_nxt  = ~r_we;
          w_wr_nxt  = r_we;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_DONE;
        w_ack_nxt   = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_maddr <= '0;
      r_mdin  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_rdata <= w_rdata_nxt;
      r_maddr <= w_maddr_nxt;
      r_mdin  <= w_mdin_nxt;
    end
  end

  assign o_ack         = r_ack;
  assign o_err         = r_err;
  assign o_rdata       = r_rdata;
  assign o_busy        = r_busy;
  assign o_mem_address = r_maddr;
  assign o_mem_datain  = r_mdin;
  assign o_mem_read    = r_rd;
  assign o_mem_write   = r_wr;

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: scoreboard of requests popped on ack, RAM
// content model, strobe/address invariants, plus WAITSTATES=0/3 latency instances.
module tb_ram_access_controller;
  localparam int W   = 1;
  localparam int RSZ = 200;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        err;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, req = 1'b0, we = 1'b0, req_x = 1'b0;
  logic [7:0]  addr = 8'h0;
  logic [15:0] wdata = 16'h0;

  logic        ack, err, busy, mrd, mwr;
  logic [15:0] rdata, mdin, mdout;
  logic [7:0]  maddr;
  logic        ack0, err0, busy0, mrd0, mwr0, ack3, err3, busy3, mrd3, mwr3;
  logic [15:0] rdata0, mdin0, mdout0, rdata3, mdin3, mdout3;
  logic [7:0]  maddr0, maddr3;

  logic [15:0] ram1 [256];
  logic [15:0] ram0 [256];
  logic [15:0] ram3 [256];
  logic [15:0] sb_mem [256];

  ram_access_controller #(.ADLINES(8), .DATALINES(16), .RAMSIZE(RSZ), .WAITSTATES(W)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_busy(busy), .o_mem_address(maddr),
    .o_mem_datain(mdin), .i_mem_dataout(mdout), .o_mem_read(mrd), .o_mem_write(mwr));

  ram_access_controller #(.ADLINES(8), .DATALINES(16), .RAMSIZE(256), .WAITSTATES(0)) u_dut_w0 (
    .i_clk(clk), .i_reset(rst), .i_req(req_x), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack0), .o_err(err0), .o_rdata(rdata0), .o_busy(busy0), .o_mem_address(maddr0),
    .o_mem_datain(mdin0), .i_mem_dataout(mdout0), .o_mem_read(mrd0), .o_mem_write(mwr0));

  ram_access_controller #(.ADLINES(8), .DATALINES(16), .RAMSIZE(256), .WAITSTATES(3)) u_dut_w3 (
    .i_clk(clk), .i_reset(rst), .i_req(req_x), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack3), .o_err(err3), .o_rdata(rdata3), .o_busy(busy3), .o_mem_address(maddr3),
    .o_mem_datain(mdin3), .i_mem_dataout(mdout3), .o_mem_read(mrd3), .o_mem_write(mwr3));

  // Level-sensitive RAMs: a write strobe held across an edge stores the word.
  always @(posedge clk) if (mwr)  ram1[maddr]  <= mdin;
  always @(posedge clk) if (mwr0) ram0[maddr0] <= mdin0;
  always @(posedge clk) if (mwr3) ram3[maddr3] <= mdin3;
  assign mdout  = ram1[maddr];
  assign mdout0 = ram0[maddr0];
  assign mdout3 = ram3[maddr3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0, n_pass = 0;
  txn_t sbq[$];
  logic [15:0] exp_rdata = 16'h0;
  logic stream_on = 1'b0;
  int   stream_start = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic w, input logic [7:0] a, input logic [15:0] d);
    txn_t t;
    t.we   = w;
    t.addr = a;
    t.err  = (int'(a) >= RSZ);
    if (!t.err && w) sb_mem[a] = d;
    t.data = w ? d : sb_mem[a];
    sbq.push_back(t);
  endtask

  task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d);
    int t = 0;
    while (busy && t < 100) begin tick(); t++; end
    if (busy) begin
      check_val("req_wait_timeout", 1, 0);
      return;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    push_txn(w, a, d);
    tick();
    req = 1'b0; we = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || sbq.size() != 0) && t < 100) begin tick(); t++; end
    check_val("idle_timeout", int'(busy), 0);
    tick();
  endtask

  // Main DUT monitor: invariants every cycle, scoreboard pop on ack.
  always @(negedge clk) begin : mon_main
    txn_t t;
    static logic       prev_busy = 1'b0, prev_strobe = 1'b0;
    static logic [7:0] prev_maddr = 8'h0;
    static int         acc_cyc = 0, last_ack_cyc = 0, wr_w = 0, rd_w = 0;
    if (rst) begin
      prev_busy = 1'b0; prev_strobe = 1'b0; prev_maddr = maddr;
      wr_w = 0; rd_w = 0; exp_rdata = 16'h0;
    end else begin
      check_val("rw_exclusive", int'(mrd & mwr), 0);
      check_val("addr_stable_strobe", int'((mrd | mwr | prev_strobe) && (maddr != prev_maddr)), 0);
      if (busy && !prev_busy) begin
        acc_cyc = cyc;
        if (stream_on && last_ack_cyc > stream_start)
          check_val("accept_gap_after_ack", cyc - last_ack_cyc, 2);
      end
      if ((mrd | mwr) && sbq.size() != 0) begin
        check_val("strobe_on_err_txn", int'(sbq[0].err), 0);
        check_val("strobe_kind", int'(mwr), int'(sbq[0].we));
        check_val("strobe_addr", int'(maddr), int'(sbq[0].addr));
        if (mwr) check_val("strobe_wdata", int'(mdin), int'(sbq[0].data));
      end
      if (mwr) wr_w++;
      else if (wr_w != 0) begin check_val("mem_write_width", wr_w, W + 1); wr_w = 0; end
      if (mrd) rd_w++;
      else if (rd_w != 0) begin check_val("mem_read_width", rd_w, W + 1); rd_w = 0; end
      if (ack) begin
        if (sbq.size() == 0) check_val("unexpected_ack", 1, 0);
        else begin
          t = sbq.pop_front();
          if (!t.err && !t.we) exp_rdata = t.data;
          check_val("ack_err", int'(err), int'(t.err));
          check_val("ack_rdata", int'(rdata), int'(exp_rdata));
          check_val("ack_latency", cyc - acc_cyc, t.err ? 0 : W + 3);
        end
        last_ack_cyc = cyc;
      end
      prev_busy   = busy;
      prev_strobe = mrd | mwr;
      prev_maddr  = maddr;
    end
  end

  int accx = 0, lat0 = -1, lat3 = -1, rdw0 = 0, rdw3 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0) lat0 = cyc - accx;
      if (ack3) lat3 = cyc - accx;
      if (mrd0) rdw0++;
      if (mrd3) rdw3++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, guard;
    logic       w;
    logic [7:0] a;
    int         bad;
    // reset values
    repeat (3) tick();
    check_val("rst_ack", int'(ack), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_mem_read", int'(mrd), 0);
    check_val("rst_mem_write", int'(mwr), 0);
    check_val("rst_rdata", int'(rdata), 0);
    check_val("rst_mem_address", int'(maddr), 0);
    check_val("rst_mem_datain", int'(mdin), 0);
    rst = 1'b0;
    tick();

    // write then read back
    do_req(1'b1, 8'h10, 16'hBEEF);
    wait_idle();
    do_req(1'b0, 8'h10, 16'h0000);
    wait_idle();
    check_val("read_back_beef", int'(rdata), 16'hBEEF);

    // out-of-range read keeps previous rdata
    do_req(1'b1, 8'h33, 16'h1234);
    wait_idle();
    do_req(1'b0, 8'h33, 16'h0000);
    wait_idle();
    do_req(1'b0, 8'hC8, 16'h0000);
    wait_idle();
    check_val("err_keeps_rdata", int'(rdata), 16'h1234);
    do_req(1'b1, 8'hFF, 16'hDEAD);
    wait_idle();

    // reset during second STROBE cycle of a write
    do_req(1'b1, 8'h05, 16'hA5A5);
    tick();
    tick();
    check_val("pre_abort_mem_write", int'(mwr), 1);
    rst = 1'b1;
    tick();
    check_val("abort_mem_write", int'(mwr), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_ack", int'(ack), 0);
    sbq.delete();
    rst = 1'b0;
    tick();
    do_req(1'b0, 8'h05, 16'h0000);
    wait_idle();
    check_val("read_after_abort", int'(rdata), 16'hA5A5);

    // reset and req together: reset wins
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h10;
    tick();
    rst = 1'b0; req = 1'b0;
    tick();
    check_val("reset_beats_req_busy", int'(busy), 0);
    check_val("reset_beats_req_rdata", int'(rdata), 0);

    // preload stream window, then stream with req held high
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 8'(8'h40 + i), 16'(16'h1000 + i));
      wait_idle();
    end
    stream_start = cyc;
    stream_on = 1'b1;
    req = 1'b1;
    n = 0;
    guard = 0;
    while (n < 16 && guard < 600) begin
      w = 1'(n % 2);
      if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(200, 255));
      else a = 8'(8'h40 + $urandom_range(0, 7));
      we = w; addr = a; wdata = 16'($urandom);
      if (!busy) begin
        push_txn(we, addr, wdata);
        n++;
      end
      tick();
      guard++;
    end
    req = 1'b0;
    check_val("stream_accepts", n, 16);
    wait_idle();
    stream_on = 1'b0;

    bad = 0;
    for (int i = 0; i < 8; i++) if (ram1[8'h40 + i] !== sb_mem[8'h40 + i]) bad++;
    check_val("ram_contents", bad, 0);

    // WAITSTATES 0 and 3: write then read 0x22
    req_x = 1'b1; we = 1'b1; addr = 8'h22; wdata = 16'h5A5A;
    tick();
    req_x = 1'b0;
    repeat (12) tick();
    lat0 = -1; lat3 = -1; rdw0 = 0; rdw3 = 0;
    req_x = 1'b1; we = 1'b0; addr = 8'h22; wdata = 16'h0;
    tick();
    accx = cyc;
    req_x = 1'b0;
    repeat (12) tick();
    check_val("w0_ack_latency", lat0, 3);
    check_val("w3_ack_latency", lat3, 6);
    check_val("w0_read_width", rdw0, 1);
    check_val("w3_read_width", rdw3, 4);
    check_val("w0_rdata", int'(rdata0), 16'h5A5A);
    check_val("w3_rdata", int'(rdata3), 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
